// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state, size and fault-cause encodings for the load/store unit
package lsu_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT} state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction/extension for loads
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);
    logic [31:0] w_lane;
    assign w_lane = i_rdata >> {i_off, 3'b000};
    always_comb begin
        o_be    = i_f3[1:0] == 2'b00 ? 4'b0001 << i_off :
                  i_f3[1:0] == 2'b01 ? 4'b0011 << i_off : 4'b1111;
        o_wdata = i_f3[1:0] == 2'b00 ? {4{i_data[7:0]}} :
                  i_f3[1:0] == 2'b01 ? {2{i_data[15:0]}} : i_data;
        o_ldata = i_f3 == F3_B  ? {{24{w_lane[7]}}, w_lane[7:0]} :
                  i_f3 == F3_H  ? {{16{w_lane[15]}}, w_lane[15:0]} :
                  i_f3 == F3_BU ? {24'b0, w_lane[7:0]} :
                  i_f3 == F3_HU ? {16'b0, w_lane[15:0]} : w_lane;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sequencing the data-memory handshake, stalls and faults
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_load,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        op_done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    state_t        r_state, w_next;
    logic [31:0]   r_addr, r_sdata, r_ldata;
    logic [2:0]    r_f3;
    logic          r_store;
    logic [1:0]    r_cause, w_cause;
    logic [CW-1:0] r_cnt;
    logic          w_accept, w_illegal, w_misalign, w_timeout, w_req;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ldata;
    lsu_align u_align (
        .i_f3    (r_f3),
        .i_off   (r_addr[1:0]),
        .i_data  (r_sdata),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );
    assign w_accept   = r_state == S_IDLE && op_valid && (op_load || op_store);
    assign w_illegal  = (op_load && op_store) ||
                        (op_store ? funct3 > F3_W : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}));
    assign w_misalign = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                        (funct3 == F3_W && addr[1:0] != 2'b00);
    assign w_timeout  = TIMEOUT != 0 && r_cnt + 1'b1 == CW'(TIMEOUT);
    assign w_req      = r_state == S_REQ;
    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        unique case (r_state)
            S_IDLE:  if (w_accept) begin
                w_next  = (w_illegal || w_misalign) ? S_FAULT : S_REQ;
                w_cause = w_illegal ? FC_ILLEGAL : FC_MISALIGN;
            end
            S_REQ:   w_next = mem_ready ? (r_store ? S_DONE : S_WAIT) : S_REQ;
            S_WAIT:  if (mem_rvalid) w_next = S_DONE;
                     else if (w_timeout) begin
                         w_next  = S_FAULT;
                         w_cause = FC_TIMEOUT;
                     end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_sdata <= '0;
            r_ldata <= '0;
            r_f3    <= '0;
            r_store <= 1'b0;
            r_cause <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            r_cnt   <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_addr  <= addr;
                r_sdata <= store_data;
                r_f3    <= funct3;
                r_store <= op_store;
            end
            if (r_state == S_WAIT && mem_rvalid) r_ldata <= w_ldata;
        end
    end
    assign stall       = w_accept || w_req || r_state == S_WAIT;
    assign op_done     = r_state == S_DONE || r_state == S_FAULT;
    assign fault       = r_state == S_FAULT;
    assign fault_cause = fault ? r_cause : 2'b00;
    assign load_data   = r_ldata;
    assign mem_req     = w_req;
    assign mem_addr    = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_we      = w_req && r_store;
    assign mem_be      = w_req ? w_be : 4'd0;
    assign mem_wdata   = w_req ? w_wdata : 32'd0;
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes alu_result as the effective address plus rs2 store data.
- Runs a request/response handshake with the data memory, steering byte lanes and sign/zero-extending load data.
- Stalls the core while an access is in flight and reports misaligned, illegal-size and timeout faults.

Parameters:
TIMEOUT, 16, max cycles in WAIT before timeout fault; 0 disables the timeout

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
op_valid  in  1  a memory instruction is presented this cycle
op_load  in  1  instruction is a load
op_store  in  1  instruction is a store
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only (stores)
addr  in  32  effective address (ALU alu_result)
store_data  in  32  rs2 value
stall  out  1  hold PC and pipeline regs
load_data  out  32  extended load result, valid when op_done
op_done  out  1  one-cycle completion pulse
fault  out  1  one-cycle fault pulse (with op_done)
fault_cause  out  2  01 misaligned, 10 illegal funct3/op, 11 timeout
mem_req  out  1  request valid
mem_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_we  out  1  write request
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0, including load_data, mem_* and fault_cause. Reset mid-access abandons the access. mem_req is 0 from the first cycle after the reset edge. A late mem_rvalid seen in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE accepts an op when op_valid & (op_load | op_store).
  - If op_load & op_store, or funct3 is illegal for the op: go to FAULT, cause 10.
  - Else if misaligned (H with addr[0] = 1, W with addr[1:0] != 0): go to FAULT, cause 01.
  - Else latch addr, funct3, load/store flag and store data; go to REQ.
- REQ: mem_req = 1. mem_addr, mem_we, mem_be and mem_wdata are registered and held stable until mem_ready. On mem_req & mem_ready: a store goes to DONE; a load goes to WAIT and clears the timeout counter.
- WAIT: the timeout counter increments each cycle.
  - mem_rvalid: capture and extend mem_rdata into load_data; go to DONE.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with no rvalid: go to FAULT, cause 11.
  - mem_rvalid in REQ, or in the same cycle as the accept, is ignored. Memory responds one or more cycles after accept.
- DONE: op_done = 1, stall = 0 for one cycle, then IDLE. op_valid in DONE is ignored (same instruction still presented).
- FAULT: op_done = 1, fault = 1, stall = 0 for one cycle, then IDLE. No memory access is issued. load_data is unchanged.
- stall = (IDLE & accepted op) | REQ | WAIT. stall is combinational in IDLE and registered-state-derived otherwise.
- Store steering, with o = addr[1:0]:
  - SB: be = 0001 << o; wdata = {4{data[7:0]}}.
  - SH: be = 0011 << o; wdata = {2{data[15:0]}}.
  - SW: be = 1111; wdata = data.
- Load extraction: the lane is mem_rdata >> (8*o). B/H are sign-extended, BU/HU zero-extended, W taken unchanged.
- Minimum latency: store 3 cycles (accept, REQ with ready, DONE); load 4 cycles with rvalid one cycle after accept.

Decomposition:
- lsu_pkg holds:
  - state enum;
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - fault cause codes (FC_MISALIGN, FC_ILLEGAL, FC_TIMEOUT).
- Sub-module lsu_align: purely combinational. Computes be/wdata from size, offset and data, and load_data from size, offset and rdata. Shared by RTL and the bench reference model.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_ready=1 in REQ -> mem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; op_done pulses 2 cycles after accept; stall high 2 cycles.
- SB addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5. SH addr=0x102, data=0x1234 -> be=1100, wdata=0x12341234.
- LB addr=0x201 with rdata=0x00008000 -> load_data=0xFFFFFF80. LBU same access -> 0x00000080. LH addr=0x202 with rdata=0x80010000 -> 0xFFFF8001.
- LW addr=0x6 -> no mem_req; fault=1, cause 01, op_done=1 one cycle after accept. LH with op_load & op_store both high -> cause 10.
- Load with mem_ready delayed 3 cycles and rvalid delayed 5 -> mem_* fields stable throughout REQ, stall high until DONE. TIMEOUT=16 with no rvalid -> cause 11 after 16 WAIT cycles.
- rst asserted while in WAIT, then mem_rvalid next cycle -> mem_req=0, state IDLE, no op_done, load_data=0.
